wbs_acq_capture: RTL and testbench

- Wishbone-streaming sink that sits directly downstream of the FMC150 ADC interface and consumes its wbs_* source stream.
- On arm plus optional trigger, writes a programmed number of samples from one selected channel tag into an internal RAM.
- Provides a synchronous read-back port, so the capture can be inspected by control logic or by a bench.

---
 rtl/wbs_acq_capture.sv | 159 +++++++++++++++
 tb/tb_wbs_acq_capture.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_acq_capture.sv
// ---------------------------------------------------------------------------
// wbs_acq_capture
// Wishbone-streaming sink placed after the FMC150 ADC interface. After an arm
// pulse (optionally followed by a trigger rising edge) it stores a programmed
// number of samples from one channel tag into an internal RAM. A synchronous
// read port lets control logic inspect the capture.
//
// Ports
//   clk_sys_i, rst_n_i          : system clock, async active-low reset
//   wbs_adr/dat/cyc/stb/we/sel_i : incoming stream transfer
//   wbs_ack/err/stall/rty_o      : stream response and back-pressure
//   arm_i, abort_i               : start / cancel pulses
//   trig_en_i, trig_i            : trigger enable and trigger level
//   chan_sel_i, num_samples_i    : tag to capture and sample count (on arm)
//   rd_addr_i, rd_data_o         : read-back port, 1-cycle latency
//   count_o, busy_o, done_o      : progress and status
// ---------------------------------------------------------------------------
module wbs_acq_capture #(
  parameter int g_wbs_adr_width  = 4,
  parameter int g_wbs_data_width = 32,
  parameter int g_mem_addr_width = 10,
  parameter int g_hold_on_done   = 1
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_n_i,
  input  logic [g_wbs_adr_width-1:0]    wbs_adr_i,
  input  logic [g_wbs_data_width-1:0]   wbs_dat_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [g_wbs_data_width/8-1:0] wbs_sel_i,
  output logic                          wbs_ack_o,
  output logic                          wbs_stall_o,
  output logic                          wbs_err_o,
  output logic                          wbs_rty_o,
  input  logic                          arm_i,
  input  logic                          abort_i,
  input  logic                          trig_en_i,
  input  logic                          trig_i,
  input  logic [g_wbs_adr_width-1:0]    chan_sel_i,
  input  logic [g_mem_addr_width:0]     num_samples_i,
  input  logic [g_mem_addr_width-1:0]   rd_addr_i,
  output logic [g_wbs_data_width-1:0]   rd_data_o,
  output logic [g_mem_addr_width:0]     count_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned DEPTH = 1 << g_mem_addr_width;
  localparam logic [g_mem_addr_width:0] DEPTH_C = {1'b1, {g_mem_addr_width{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [g_mem_addr_width:0]     count_q, count_d;
  logic [g_mem_addr_width:0]     target_q, target_d;
  logic                          stall_q, stall_d;
  logic                          ack_q, err_q;
  logic                          trig_prev_q;
  logic [g_wbs_data_width-1:0]   rd_data_q;
  logic [g_wbs_data_width-1:0]   mem_q [0:DEPTH-1];

  logic                          accept;
  logic                          xfer_ok;
  logic                          trig_rise;
  logic                          wr_en;
  logic [g_mem_addr_width:0]     arm_target;

  assign accept     = wbs_cyc_i & wbs_stb_i & ~stall_q;
  assign xfer_ok    = wbs_we_i & (&wbs_sel_i);
  assign trig_rise  = trig_i & ~trig_prev_q;
  // Requests beyond the RAM depth are clamped so the write pointer never wraps.
  assign arm_target = (num_samples_i > DEPTH_C) ? DEPTH_C : num_samples_i;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    wr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          target_d = arm_target;
          count_d  = '0;
          state_d  = trig_en_i ? ST_WAIT_TRIG : ST_CAPTURE;
        end
      end
      ST_WAIT_TRIG: begin
        if (trig_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (count_q >= target_q) begin
          // Zero-length capture: leave without writing.
          state_d = ST_DONE;
        end else if (accept && xfer_ok && (wbs_adr_i == chan_sel_i)) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_d == target_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over arm and over the state change of a final write; the
    // write itself and its count update still go through.
    if (abort_i) state_d = ST_IDLE;

    stall_d = (state_d == ST_DONE) && (g_hold_on_done != 0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      target_q    <= '0;
      stall_q     <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      trig_prev_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      target_q    <= target_d;
      stall_q     <= stall_d;
      ack_q       <= accept & xfer_ok;
      err_q       <= accept & ~xfer_ok;
      trig_prev_q <= trig_i;
      // Read-before-write: a same-address write in this cycle is not visible.
      rd_data_q   <= mem_q[rd_addr_i];
    end
  end

  // NOTE: the RAM has no reset so it maps onto block RAM; its contents are
  // undefined until written.
  always_ff @(posedge clk_sys_i) begin
    if (wr_en) mem_q[count_q[g_mem_addr_width-1:0]] <= wbs_dat_i;
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_stall_o = stall_q;
  assign wbs_rty_o   = 1'b0;
  assign rd_data_o   = rd_data_q;
  assign count_o     = count_q;
  assign busy_o      = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_wbs_acq_capture.sv
// ---------------------------------------------------------------------------
// tb_wbs_acq_capture
// Directed bench for wbs_acq_capture with default parameters (4-bit tags,
// 32-bit data, 1024-word RAM, stall while DONE). Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_wbs_acq_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wbs_adr;
  logic [31:0] wbs_dat;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic        wbs_ack, wbs_stall, wbs_err, wbs_rty;
  logic        arm, abort_p, trig_en, trig;
  logic [3:0]  chan_sel;
  logic [10:0] num_samples;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic [10:0] count;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wbs_acq_capture dut (
    .clk_sys_i    (clk),
    .rst_n_i      (rst_n),
    .wbs_adr_i    (wbs_adr),
    .wbs_dat_i    (wbs_dat),
    .wbs_cyc_i    (wbs_cyc),
    .wbs_stb_i    (wbs_stb),
    .wbs_we_i     (wbs_we),
    .wbs_sel_i    (wbs_sel),
    .wbs_ack_o    (wbs_ack),
    .wbs_stall_o  (wbs_stall),
    .wbs_err_o    (wbs_err),
    .wbs_rty_o    (wbs_rty),
    .arm_i        (arm),
    .abort_i      (abort_p),
    .trig_en_i    (trig_en),
    .trig_i       (trig),
    .chan_sel_i   (chan_sel),
    .num_samples_i(num_samples),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .count_o      (count),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One stream transfer; returns the response seen the following cycle.
  task automatic send(input logic [3:0] adr, input logic [31:0] dat,
                      input logic we, input logic [3:0] sel,
                      output logic ack, output logic err);
    wbs_adr = adr; wbs_dat = dat; wbs_we = we; wbs_sel = sel;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    step();
    ack = wbs_ack; err = wbs_err;
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
  endtask

  task automatic do_arm(input logic ten, input logic [3:0] ch, input logic [10:0] n);
    trig_en = ten; chan_sel = ch; num_samples = n;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wbs_adr = '0; wbs_dat = '0; wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = '0;
    arm = 0; abort_p = 0; trig_en = 0; trig = 0; chan_sel = '0; num_samples = '0;
    rd_addr = '0;
    #1;
    total++;
    if ({wbs_ack, wbs_err, wbs_stall, wbs_rty, busy, done, count, rd_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b err=%b stall=%b rty=%b busy=%b done=%b count=%0d rd=%h, expected all 0",
               wbs_ack, wbs_err, wbs_stall, wbs_rty, busy, done, count, rd_data);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_stream();
    logic a, e;
    for (int i = 0; i < 10; i++) begin
      send(4'(i), 32'(i), 1'b1, 4'hF, a, e);
      total++;
      if ({a, e} !== 2'b10) begin
        bad++;
        $display("FAIL idle_ack[%0d]: got ack=%b err=%b, expected ack=1 err=0", i, a, e);
      end
    end
    step();
    total++;
    if ({wbs_ack, wbs_err, count, done, wbs_stall} !== '0) begin
      bad++;
      $display("FAIL idle_after: got ack=%b err=%b count=%0d done=%b stall=%b, expected all 0",
               wbs_ack, wbs_err, count, done, wbs_stall);
    end
  endtask

  task automatic test_capture();
    logic a, e;
    do_arm(1'b0, 4'd2, 11'd8);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL cap_busy: got %b expected 1", busy);
    end
    for (int i = 0; i < 16; i++) begin
      send((i % 2 == 0) ? 4'd1 : 4'd2, 32'(i), 1'b1, 4'hF, a, e);
      if (i == 14) begin
        total++;
        if ({done, count} !== {1'b0, 11'd7}) begin
          bad++;
          $display("FAIL cap_before_last: got done=%b count=%0d, expected done=0 count=7", done, count);
        end
      end
    end
    total++;
    if ({done, busy, wbs_stall, count} !== {3'b101, 11'd8}) begin
      bad++;
      $display("FAIL cap_done: got done=%b busy=%b stall=%b count=%0d, expected 1 0 1 8",
               done, busy, wbs_stall, count);
    end
    send(4'd2, 32'hDEAD, 1'b1, 4'hF, a, e);
    total++;
    if ({a, e, count} !== {2'b00, 11'd8}) begin
      bad++;
      $display("FAIL cap_stalled: got ack=%b err=%b count=%0d, expected 0 0 8", a, e, count);
    end
    for (int k = 0; k < 8; k++) begin
      rd_addr = 10'(k);
      step();
      total++;
      if (rd_data !== 32'(2 * k + 1)) begin
        bad++;
        $display("FAIL cap_ram[%0d]: got %h expected %h", k, rd_data, 32'(2 * k + 1));
      end
    end
  endtask

  task automatic test_trigger();
    logic a, e;
    do_arm(1'b1, 4'd3, 11'd4);
    for (int i = 0; i < 5; i++) begin
      send(4'd3, 32'hA0 + 32'(i), 1'b1, 4'hF, a, e);
      total++;
      if ({a, e, count, busy} !== {2'b10, 11'd0, 1'b1}) begin
        bad++;
        $display("FAIL trig_pre[%0d]: got ack=%b err=%b count=%0d busy=%b, expected 1 0 0 1", i, a, e, count, busy);
      end
    end
    // Transfer in the edge cycle must be dropped.
    trig = 1'b1;
    send(4'd3, 32'hEE, 1'b1, 4'hF, a, e);
    trig = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd3, 32'hB0 + 32'(i), 1'b1, 4'hF, a, e);
    total++;
    if ({done, count} !== {1'b1, 11'd4}) begin
      bad++;
      $display("FAIL trig_done: got done=%b count=%0d, expected 1 4", done, count);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 10'(k);
      step();
      total++;
      if (rd_data !== 32'hB0 + 32'(k)) begin
        bad++;
        $display("FAIL trig_ram[%0d]: got %h expected %h", k, rd_data, 32'hB0 + 32'(k));
      end
    end
  endtask

  task automatic test_errors();
    logic a, e;
    do_arm(1'b0, 4'd5, 11'd4);
    send(4'd5, 32'hC0, 1'b1, 4'hF, a, e);
    send(4'd5, 32'h11, 1'b0, 4'hF, a, e);
    total++;
    if ({a, e, count} !== {2'b01, 11'd1}) begin
      bad++;
      $display("FAIL err_we0: got ack=%b err=%b count=%0d, expected 0 1 1", a, e, count);
    end
    send(4'd5, 32'h22, 1'b1, 4'b0011, a, e);
    total++;
    if ({a, e, count} !== {2'b01, 11'd1}) begin
      bad++;
      $display("FAIL err_sel: got ack=%b err=%b count=%0d, expected 0 1 1", a, e, count);
    end
    step();
    total++;
    if ({wbs_ack, wbs_err} !== 2'b00) begin
      bad++;
      $display("FAIL err_no_resp: got ack=%b err=%b, expected 0 0", wbs_ack, wbs_err);
    end
    for (int i = 1; i < 4; i++) send(4'd5, 32'hC0 + 32'(i), 1'b1, 4'hF, a, e);
    total++;
    if ({done, count} !== {1'b1, 11'd4}) begin
      bad++;
      $display("FAIL err_done: got done=%b count=%0d, expected 1 4", done, count);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 10'(k);
      step();
      total++;
      if (rd_data !== 32'hC0 + 32'(k)) begin
        bad++;
        $display("FAIL err_ram[%0d]: got %h expected %h", k, rd_data, 32'hC0 + 32'(k));
      end
    end
  endtask

  task automatic test_clamp();
    logic a, e;
    do_arm(1'b0, 4'd0, 11'd2047);
    for (int i = 0; i < 1023; i++) begin
      if (i == 2) rd_addr = 10'd2;
      send(4'd0, 32'(i), 1'b1, 4'hF, a, e);
      if (i == 2) begin
        total++;
        if (rd_data !== 32'hC2) begin
          bad++;
          $display("FAIL rdw_old: got %h expected %h", rd_data, 32'hC2);
        end
      end
      if (i == 3) begin
        total++;
        if (rd_data !== 32'd2) begin
          bad++;
          $display("FAIL rdw_new: got %h expected %h", rd_data, 32'd2);
        end
      end
    end
    total++;
    if ({done, count} !== {1'b0, 11'd1023}) begin
      bad++;
      $display("FAIL clamp_1023: got done=%b count=%0d, expected 0 1023", done, count);
    end
    send(4'd0, 32'd1023, 1'b1, 4'hF, a, e);
    total++;
    if ({done, count} !== {1'b1, 11'd1024}) begin
      bad++;
      $display("FAIL clamp_done: got done=%b count=%0d, expected 1 1024", done, count);
    end
    rd_addr = 10'd1023;
    step();
    total++;
    if (rd_data !== 32'd1023) begin
      bad++;
      $display("FAIL clamp_ram_last: got %h expected %h", rd_data, 32'd1023);
    end
  endtask

  task automatic test_zero();
    do_arm(1'b0, 4'd0, 11'd0);
    total++;
    if ({busy, done, count} !== {2'b10, 11'd0}) begin
      bad++;
      $display("FAIL zero_arm: got busy=%b done=%b count=%0d, expected 1 0 0", busy, done, count);
    end
    step();
    total++;
    if ({busy, done, wbs_stall, count} !== {3'b011, 11'd0}) begin
      bad++;
      $display("FAIL zero_done: got busy=%b done=%b stall=%b count=%0d, expected 0 1 1 0",
               busy, done, wbs_stall, count);
    end
  endtask

  task automatic test_abort();
    logic a, e;
    do_arm(1'b0, 4'd1, 11'd8);
    for (int i = 0; i < 3; i++) send(4'd1, 32'h50 + 32'(i), 1'b1, 4'hF, a, e);
    abort_p = 1'b1;
    arm = 1'b1;
    step();
    abort_p = 1'b0;
    arm = 1'b0;
    total++;
    if ({busy, done, wbs_stall, count} !== {3'b000, 11'd3}) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b done=%b stall=%b count=%0d, expected 0 0 0 3",
               busy, done, wbs_stall, count);
    end
    send(4'd1, 32'h99, 1'b1, 4'hF, a, e);
    total++;
    if ({a, count} !== {1'b1, 11'd3}) begin
      bad++;
      $display("FAIL abort_drop: got ack=%b count=%0d, expected 1 3", a, count);
    end
  endtask

  task automatic test_reset_mid();
    logic a, e;
    rd_addr = 10'd0;
    do_arm(1'b0, 4'd1, 11'd8);
    send(4'd1, 32'h77, 1'b1, 4'hF, a, e);
    send(4'd1, 32'h78, 1'b1, 4'hF, a, e);
    rst_n = 1'b0;
    #1;
    total++;
    if ({wbs_ack, wbs_err, wbs_stall, busy, done, count, rd_data} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got ack=%b err=%b stall=%b busy=%b done=%b count=%0d rd=%h, expected all 0",
               wbs_ack, wbs_err, wbs_stall, busy, done, count, rd_data);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_idle_stream();
    test_capture();
    test_trigger();
    test_errors();
    test_clamp();
    test_zero();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
